// File: rtl/uart_tx_scheduler_if.sv
// FIFO-side bus of the UART transmit scheduler: write strobe, data byte,
// full back-pressure and the sticky overrun flag.
interface uart_tx_scheduler_if;
    logic [7:0] w_data;
    logic [2:0] op_code_data;
    logic       wr_uart;
    logic       tx_full;
    logic       overrun;

    modport master (
        output w_data,
        output op_code_data,
        output wr_uart,
        output overrun,
        input  tx_full
    );

    modport slave (
        input  w_data,
        input  op_code_data,
        input  wr_uart,
        input  overrun,
        output tx_full
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Two-player link transmitter: tracks four message sources, sends changed
// bytes round-robin into the UART TX FIFO and fills silence with heartbeats.
module uart_tx_scheduler #(
    parameter int         HEARTBEAT_CYCLES = 650_000,
    parameter logic [7:0] HEARTBEAT_BYTE   = 8'h07
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 data_game_state_sel,
    input  logic [7:0]                 data_shoot_control,
    input  logic [7:0]                 data_mouse_control,
    input  logic [7:0]                 data_score_control,
    uart_tx_scheduler_if.master        tx_bus
);
    localparam int             CNT_W   = $clog2(HEARTBEAT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HEARTBEAT_CYCLES - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state;
    state_t           state_next;
    logic [7:0]       src [4];
    logic [7:0]       shadow [4];
    logic [3:0]       pending;
    logic [3:0]       live_vec;
    logic [3:0]       grant_vec;
    logic [1:0]       rr_ptr;
    logic [1:0]       grant_idx;
    logic [1:0]       cand;
    logic [CNT_W-1:0] hb_cnt;
    logic             hb_due;
    logic [7:0]       w_data;
    logic             overrun;
    logic             wr_uart;
    logic             data_grant;
    logic             hb_grant;
    logic             tx_full;

    assign src[0] = data_game_state_sel;
    assign src[1] = data_shoot_control;
    assign src[2] = data_mouse_control;
    assign src[3] = data_score_control;

    assign tx_full             = tx_bus.tx_full;
    assign tx_bus.w_data       = w_data;
    assign tx_bus.op_code_data = w_data[2:0];
    assign tx_bus.wr_uart      = wr_uart;
    assign tx_bus.overrun      = overrun;

    // A source needs sending when it moved to a value with a non-null opcode.
    always_comb begin
        live_vec = '0;
        for (int i = 0; i < 4; i++) begin
            if (src[i] != shadow[i] && src[i][2:0] != 3'b000) begin
                live_vec[i] = 1'b1;
            end
        end
    end

    // Scan downward so the set index closest above rr_ptr wins last.
    always_comb begin
        grant_idx = rr_ptr;
        cand      = rr_ptr;
        for (int k = 3; k >= 0; k--) begin
            cand = rr_ptr + 2'(k);
            if (pending[cand]) begin
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        state_next = state;
        data_grant = 1'b0;
        hb_grant   = 1'b0;
        wr_uart    = 1'b0;
        case (state)
            IDLE: begin
                if (|pending) begin
                    data_grant = 1'b1;
                    state_next = SEND;
                end else if (hb_due) begin
                    hb_grant   = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                wr_uart = !tx_full;
                if (!tx_full) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign grant_vec = data_grant ? 4'(4'b0001 << grant_idx) : 4'b0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A fresh change on the source being granted keeps its pending bit set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= '0;
            end
            pending <= '0;
            overrun <= 1'b0;
            rr_ptr  <= '0;
            w_data  <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= src[i];
            end
            pending <= (pending & ~grant_vec) | live_vec;
            if (|(live_vec & pending & ~grant_vec)) begin
                overrun <= 1'b1;
            end
            if (data_grant) begin
                w_data <= shadow[grant_idx];
                rr_ptr <= grant_idx + 2'd1;
            end else if (hb_grant) begin
                w_data <= HEARTBEAT_BYTE;
            end
        end
    end

    // Any write restarts the heartbeat interval and cancels a due heartbeat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hb_cnt <= '0;
            hb_due <= 1'b0;
        end else begin
            if (wr_uart) begin
                hb_cnt <= '0;
            end else if (hb_cnt != CNT_MAX) begin
                hb_cnt <= hb_cnt + CNT_W'(1);
            end
            if (wr_uart || hb_grant) begin
                hb_due <= 1'b0;
            end else if (hb_cnt == CNT_MAX) begin
                hb_due <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: per-cycle vector table for the data
// path plus hand sequences for back-pressure, supersede, reset and heartbeat.
module tb_uart_tx_scheduler;
    logic clk = 1'b0;
    logic rst;
    logic hb_rst;
    logic [7:0] src [4];
    logic [7:0] hb_src [4];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] wr_log [$];
    logic [7:0] hb_dat_log [$];
    int         hb_cyc_log [$];

    typedef struct {
        logic [7:0] s0;
        logic [7:0] s1;
        logic [7:0] s2;
        logic [7:0] s3;
        logic       full;
        logic       exp_wr;
        logic [7:0] exp_wdata;
        logic       exp_overrun;
    } vec_t;

    vec_t vecs [18];

    always #5 clk = ~clk;

    uart_tx_scheduler_if bus();
    uart_tx_scheduler_if hb_bus();

    uart_tx_scheduler dut (
        .clk                 (clk),
        .rst                 (rst),
        .data_game_state_sel (src[0]),
        .data_shoot_control  (src[1]),
        .data_mouse_control  (src[2]),
        .data_score_control  (src[3]),
        .tx_bus              (bus)
    );

    uart_tx_scheduler #(.HEARTBEAT_CYCLES(16), .HEARTBEAT_BYTE(8'h07)) dut_hb (
        .clk                 (clk),
        .rst                 (hb_rst),
        .data_game_state_sel (hb_src[0]),
        .data_shoot_control  (hb_src[1]),
        .data_mouse_control  (hb_src[2]),
        .data_score_control  (hb_src[3]),
        .tx_bus              (hb_bus)
    );

    // Record every FIFO write seen at the closing edge of its cycle.
    always @(posedge clk) begin
        if (bus.wr_uart === 1'b1) begin
            wr_log.push_back(bus.w_data);
        end
        if (hb_bus.wr_uart === 1'b1) begin
            hb_dat_log.push_back(hb_bus.w_data);
            hb_cyc_log.push_back(cyc);
        end
        cyc <= cyc + 1;
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        src[0] = v.s0;
        src[1] = v.s1;
        src[2] = v.s2;
        src[3] = v.s3;
        bus.tx_full = v.full;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
        end
    endtask

    initial begin
        vecs[0]  = '{8'h00, 8'h00, 8'h00, 8'h2B, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{8'h00, 8'h00, 8'h00, 8'h2B, 1'b0, 1'b1, 8'h2B, 1'b0};
        vecs[2]  = '{8'h00, 8'h00, 8'h00, 8'h2B, 1'b0, 1'b0, 8'h2B, 1'b0};
        vecs[3]  = '{8'h00, 8'h00, 8'h00, 8'h2B, 1'b0, 1'b0, 8'h2B, 1'b0};
        vecs[4]  = '{8'h09, 8'h12, 8'h1B, 8'h24, 1'b0, 1'b0, 8'h2B, 1'b0};
        vecs[5]  = '{8'h09, 8'h12, 8'h1B, 8'h24, 1'b0, 1'b1, 8'h09, 1'b0};
        vecs[6]  = '{8'h09, 8'h12, 8'h1B, 8'h24, 1'b0, 1'b0, 8'h09, 1'b0};
        vecs[7]  = '{8'h09, 8'h12, 8'h1B, 8'h24, 1'b0, 1'b1, 8'h12, 1'b0};
        vecs[8]  = '{8'h09, 8'h12, 8'h1B, 8'h24, 1'b0, 1'b0, 8'h12, 1'b0};
        vecs[9]  = '{8'h09, 8'h12, 8'h1B, 8'h24, 1'b0, 1'b1, 8'h1B, 1'b0};
        vecs[10] = '{8'h09, 8'h12, 8'h1B, 8'h24, 1'b0, 1'b0, 8'h1B, 1'b0};
        vecs[11] = '{8'h09, 8'h12, 8'h1B, 8'h24, 1'b0, 1'b1, 8'h24, 1'b0};
        vecs[12] = '{8'h09, 8'h12, 8'h1B, 8'h24, 1'b0, 1'b0, 8'h24, 1'b0};
        vecs[13] = '{8'h11, 8'h12, 8'h1B, 8'h2C, 1'b0, 1'b0, 8'h24, 1'b0};
        vecs[14] = '{8'h11, 8'h12, 8'h1B, 8'h2C, 1'b0, 1'b1, 8'h11, 1'b0};
        vecs[15] = '{8'h11, 8'h12, 8'h1B, 8'h2C, 1'b0, 1'b0, 8'h11, 1'b0};
        vecs[16] = '{8'h11, 8'h12, 8'h1B, 8'h2C, 1'b0, 1'b1, 8'h2C, 1'b0};
        vecs[17] = '{8'h11, 8'h12, 8'h1B, 8'h2C, 1'b0, 1'b0, 8'h2C, 1'b0};

        rst = 1'b1;
        hb_rst = 1'b1;
        bus.tx_full = 1'b0;
        hb_bus.tx_full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            src[i] = 8'h00;
            hb_src[i] = 8'h00;
        end
        step(2);
        check_output("reset wr_uart", 32'(bus.wr_uart), 32'h0);
        check_output("reset w_data", 32'(bus.w_data), 32'h0);
        check_output("reset overrun", 32'(bus.overrun), 32'h0);
        rst = 1'b0;

        // Single message, four-way arbitration and pointer wrap.
        for (int j = 0; j < 18; j++) begin
            apply_stimulus(vecs[j]);
            step(1);
            check_output($sformatf("vec%0d wr_uart", j), 32'(bus.wr_uart), 32'(vecs[j].exp_wr));
            check_output($sformatf("vec%0d w_data", j), 32'(bus.w_data), 32'(vecs[j].exp_wdata));
            check_output($sformatf("vec%0d overrun", j), 32'(bus.overrun), 32'(vecs[j].exp_overrun));
        end
        check_output("op_code_data", 32'(bus.op_code_data), 32'h4);

        // Back-pressure: source 2 pending at 0x1A held behind tx_full.
        wr_log.delete();
        bus.tx_full = 1'b1;
        src[2] = 8'h1A;
        step(2);
        for (int i = 0; i < 10; i++) begin
            check_output($sformatf("bp%0d wr_uart", i), 32'(bus.wr_uart), 32'h0);
            check_output($sformatf("bp%0d w_data", i), 32'(bus.w_data), 32'h1A);
            step(1);
        end
        bus.tx_full = 1'b0;
        #1;
        check_output("bp release wr_uart", 32'(bus.wr_uart), 32'h1);
        step(1);
        check_output("bp after wr_uart", 32'(bus.wr_uart), 32'h0);
        step(4);
        check_output("bp write count", 32'(wr_log.size()), 32'h1);
        if (wr_log.size() >= 1) check_output("bp write data", 32'(wr_log[0]), 32'h1A);

        // Source 0 changes again in the very cycle it is granted.
        wr_log.delete();
        src[0] = 8'h21;
        step(1);
        src[0] = 8'h29;
        step(6);
        check_output("coincide count", 32'(wr_log.size()), 32'h2);
        if (wr_log.size() >= 2) begin
            check_output("coincide first", 32'(wr_log[0]), 32'h21);
            check_output("coincide second", 32'(wr_log[1]), 32'h29);
        end
        check_output("coincide overrun", 32'(bus.overrun), 32'h0);

        // Supersede: 0x19 replaced by 0x1D while still pending.
        wr_log.delete();
        bus.tx_full = 1'b1;
        src[1] = 8'h11;
        step(2);
        src[1] = 8'h19;
        step(1);
        src[1] = 8'h1D;
        step(1);
        check_output("sup overrun", 32'(bus.overrun), 32'h1);
        check_output("sup w_data", 32'(bus.w_data), 32'h11);
        check_output("sup wr_uart", 32'(bus.wr_uart), 32'h0);
        bus.tx_full = 1'b0;
        step(6);
        check_output("sup count", 32'(wr_log.size()), 32'h2);
        if (wr_log.size() >= 2) begin
            check_output("sup first", 32'(wr_log[0]), 32'h11);
            check_output("sup second", 32'(wr_log[1]), 32'h1D);
        end
        check_output("sup overrun sticky", 32'(bus.overrun), 32'h1);

        // Null opcode updates the shadow only.
        wr_log.delete();
        src[0] = 8'h08;
        step(6);
        check_output("null count", 32'(wr_log.size()), 32'h0);
        check_output("null w_data", 32'(bus.w_data), 32'h1D);

        // Asynchronous reset in the middle of a SEND.
        bus.tx_full = 1'b1;
        src[3] = 8'h2B;
        step(2);
        check_output("rst pre w_data", 32'(bus.w_data), 32'h2B);
        wr_log.delete();
        bus.tx_full = 1'b0;
        #1;
        check_output("rst pre wr_uart", 32'(bus.wr_uart), 32'h1);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) src[i] = 8'h00;
        #1;
        check_output("rst wr_uart", 32'(bus.wr_uart), 32'h0);
        check_output("rst w_data", 32'(bus.w_data), 32'h0);
        check_output("rst overrun", 32'(bus.overrun), 32'h0);
        step(2);
        rst = 1'b0;
        step(6);
        check_output("rst no write", 32'(wr_log.size()), 32'h0);

        // Heartbeat every 18 cycles; a data write restarts the spacing.
        hb_rst = 1'b0;
        begin
            int budget = 0;
            while (hb_cyc_log.size() < 3 && budget < 200) begin
                step(1);
                budget++;
            end
        end
        check_output("hb wait", 32'(hb_cyc_log.size() >= 3), 32'h1);
        if (hb_cyc_log.size() >= 3) begin
            check_output("hb gap1", 32'(hb_cyc_log[1] - hb_cyc_log[0]), 32'd18);
            check_output("hb gap2", 32'(hb_cyc_log[2] - hb_cyc_log[1]), 32'd18);
            check_output("hb byte0", 32'(hb_dat_log[0]), 32'h07);
            check_output("hb byte2", 32'(hb_dat_log[2]), 32'h07);
        end
        step(5);
        hb_src[3] = 8'h2B;
        begin
            int budget = 0;
            while (hb_cyc_log.size() < 5 && budget < 100) begin
                step(1);
                budget++;
            end
        end
        check_output("hb data wait", 32'(hb_cyc_log.size() >= 5), 32'h1);
        if (hb_cyc_log.size() >= 5) begin
            check_output("hb data byte", 32'(hb_dat_log[3]), 32'h2B);
            check_output("hb data latency", 32'(hb_cyc_log[3] - hb_cyc_log[2]), 32'd8);
            check_output("hb after data byte", 32'(hb_dat_log[4]), 32'h07);
            check_output("hb after data gap", 32'(hb_cyc_log[4] - hb_cyc_log[3]), 32'd18);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation timed out");
    end
endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Transmit-side link scheduler for two-player mode. It collects the 8-bit message bytes produced by the game-state, shoot, mouse and score control blocks and detects when any of them changes. It arbitrates the changed bytes round-robin and writes them one at a time into the UART transmit FIFO, honouring `tx_full`. When the link is otherwise silent it inserts a periodic heartbeat byte so the peer's `uart_decoder` keeps `connect_corrected` asserted. It is the sending counterpart of `uart_decoder`: every byte is `{payload[4:0], opcode[2:0]}`.

## Interface
Parameters:
- `HEARTBEAT_CYCLES`, default 650_000: number of idle cycles without a write before a heartbeat is due.
- `HEARTBEAT_BYTE`, default 8'h07: heartbeat byte value, opcode 3'b111.

Ports:
- `clk` in 1: system clock, single clock domain.
- `rst` in 1: reset, asynchronous, active-high.
- `data_game_state_sel` in 8: message source 0.
- `data_shoot_control` in 8: message source 1.
- `data_mouse_control` in 8: message source 2.
- `data_score_control` in 8: message source 3.
- `tx_full` in 1: UART TX FIFO full.
- `w_data` out 8: byte to the FIFO. Held stable between loads; bits [2:0] are also fanned out as `op_code_data`.
- `wr_uart` out 1: FIFO write strobe, one cycle per byte.
- `overrun` out 1: sticky flag. Set when a pending byte is superseded before being sent.

## Operation
- Per source i there is a shadow register `shadow[i]` and a flag `pending[i]`. Every cycle where `src[i] != shadow[i]`:
  - `shadow[i] <= src[i]`.
  - If `src[i][2:0] != 3'b000`, set `pending[i]`. If `pending[i]` was already set and is not being granted this cycle, set `overrun`.
  - A byte with opcode 000 is a null message: it updates the shadow but is never transmitted.
- Heartbeat counter:
  - Width is `$clog2(HEARTBEAT_CYCLES+1)`.
  - Cleared in any cycle with `wr_uart=1`; otherwise increments, saturating at `HEARTBEAT_CYCLES-1`.
  - When its value is `HEARTBEAT_CYCLES-1`, `hb_due <= 1`.
- FSM with two states, IDLE and SEND:
  - **IDLE.** If any `pending` bit is set, search from `rr_ptr` upward (mod 4) and grant the first set index g. On grant: `w_data <= shadow[g]`, clear `pending[g]`, `rr_ptr <= g+1` (mod 4), go to SEND.
  - **IDLE, no pending but `hb_due`.** `w_data <= HEARTBEAT_BYTE`, clear `hb_due`, go to SEND. Data always beats heartbeat.
  - **SEND.** `wr_uart = (state==SEND) && !tx_full`, combinational from the registered state. When `wr_uart=1`, go to IDLE next edge. While `tx_full=1`, stay in SEND with `w_data` frozen.
- Grant coincident with a new change of the same source: the pending flag stays set and the shadow takes the new value. The new value is sent in a later grant; `overrun` is not set.
- Reset values: state IDLE, `w_data=0`, `wr_uart=0`, `overrun=0`, all shadows 0, `pending=0`, `rr_ptr=0`, `hb_due=0`, counter 0.
- Reset mid-SEND aborts the byte: no write, no replay.

## Timing
- Source change sampled at edge k. Grant at edge k+1. `wr_uart` is high during the cycle after edge k+1 if `tx_full=0`. Latency is 2 cycles.
- Maximum throughput is one byte every 2 cycles.
- Four simultaneous changes with `rr_ptr=0` and `tx_full=0` produce writes in source order 0, 1, 2, 3 in cycles k+2, k+4, k+6, k+8.
- Heartbeat: with `tx_full=0` and no data, `wr_uart` pulses every `HEARTBEAT_CYCLES+2` cycles.
- `tx_full` deasserting in SEND gives `wr_uart` in the same cycle, exactly once.
- `w_data` changes only on an IDLE→SEND edge.

## Test plan
- Reset: assert `rst` asynchronously mid-SEND with `w_data=8'h2B` → `wr_uart` drops immediately, `w_data=0`, `overrun=0`, no write after release.
- Single message: `data_score_control` changes 0x00→0x2B with `tx_full=0` → exactly one `wr_uart` pulse 2 cycles later with `w_data=0x2B`, and `w_data` holds 0x2B afterwards.
- Arbitration: all four sources change at once to 0x09, 0x12, 0x1B, 0x24 → writes 0x09, 0x12, 0x1B, 0x24 at 2-cycle spacing. A subsequent change of source 0 to 0x11 while source 3 changes to 0x2C → source 0 (0x11) is written first, then source 3 (0x2C), since the pointer wrapped to 0.
- Backpressure: hold `tx_full=1` for 10 cycles with source 2 pending at 0x1A → `wr_uart` stays 0 and `w_data=0x1A` is stable. On release, exactly one write of 0x1A.
- Supersede and null: with `tx_full=1` and source 0x11 already granted and latched in `w_data` (FSM in SEND), source 1 changes 0x11→0x19 (pending, not yet granted), then →0x1D while still pending → `overrun=1`; on release the bytes written are 0x11 then 0x1D only. Source 0 changes to 0x08 (opcode 0) → no write.
- Heartbeat: set `HEARTBEAT_CYCLES=16` with the bus idle → 0x07 is written every 18 cycles. A data write at any point restarts the 18-cycle spacing from that write.
